hdlc_rx_protocol_monitor: RTL

Synthesizable, parametrised HDLC Rx protocol checker bound alongside the Rx datapath in sim, emulation or silicon debug. Watches the serial Rx line and the Rx status strobes, then checks three things: flag-detect latency, abort-signal latency, and overflow after the buffer byte limit. Latencies and buffer depth are configurable. Each check type has its own per-cycle error pulse and saturating counter, plus a frame-tracking FSM.

---
 rtl/hdlc_rx_protocol_monitor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/hdlc_rx_protocol_monitor.sv
// hdlc_rx_protocol_monitor
// HDLC Rx protocol checker. It watches the serial Rx line and the Rx status
// strobes, and checks flag-detect latency, abort-signal latency and buffer
// overflow. Each check has a one-cycle error pulse and a saturating counter.
// A two-state frame tracker (IDLE/OPEN) counts buffer writes per frame.
// Optional build macro: HDLC_MON_PASS_CNT_EN adds per-check pass counters.
module hdlc_rx_protocol_monitor #(
    parameter int FLAG_LAT  = 2,
    parameter int ABORT_LAT = 1,
    parameter int OVF_LAT   = 1,
    parameter int MAX_LAT   = 8,
    parameter int MAX_BYTES = 128,
    parameter int CNT_W     = 16
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              Rx,
    input  logic                              Rx_FlagDetect,
    input  logic                              Rx_ValidFrame,
    input  logic                              Rx_AbortDetect,
    input  logic                              Rx_AbortSignal,
    input  logic                              Rx_Overflow,
    input  logic                              Rx_WrBuff,
    input  logic [2:0]                        ChkEn,
    input  logic                              CntClr,
    output logic [2:0]                        ErrPulse,
    output logic [CNT_W-1:0]                  ErrCntFlag,
    output logic [CNT_W-1:0]                  ErrCntAbort,
    output logic [CNT_W-1:0]                  ErrCntOvf,
    output logic [CNT_W-1:0]                  ErrCntTotal,
    output logic                              FrameActive,
    output logic [$clog2(MAX_BYTES+2)-1:0]    ByteCnt
`ifdef HDLC_MON_PASS_CNT_EN
    ,
    output logic [CNT_W-1:0]                  PassCntFlag,
    output logic [CNT_W-1:0]                  PassCntAbort,
    output logic [CNT_W-1:0]                  PassCntOvf
`endif
);

    localparam int              BC_W       = $clog2(MAX_BYTES + 2);
    localparam logic [BC_W-1:0] BYTES_FULL = BC_W'(MAX_BYTES);
    localparam logic [BC_W-1:0] BYTES_OVER = BC_W'(MAX_BYTES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [6:0]         rxHist;       // [0] = previous sample, [6] = seven samples ago
    logic [MAX_LAT-1:0] flagPipe;
    logic [MAX_LAT-1:0] abortPipe;
    logic [MAX_LAT-1:0] ovfPipe;
    logic               ovfSeen;
    logic               ovfPrev;

    logic               flagMatch;
    logic               idleMatch;
    logic               ovfPush;
    logic               flagDue;
    logic               abortDue;
    logic               ovfDue;
    logic               spurOvf;
    logic [2:0]         errNow;
    logic [1:0]         errCount;

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       n);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W - 1){1'b0}}, n};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Pattern matching, expectation evaluation and error classification
    always_comb begin
        flagMatch = ~rxHist[6] & (&rxHist[5:0]) & ~Rx;
        // Seven ones in a row; an abort pattern is a subset of this
        idleMatch = (&rxHist[5:0]) & Rx;
        ovfPush   = (state == OPEN) & Rx_WrBuff & ~flagMatch & (ByteCnt == BYTES_FULL);
        flagDue   = flagPipe[FLAG_LAT-1];
        abortDue  = abortPipe[ABORT_LAT-1];
        ovfDue    = ovfPipe[OVF_LAT-1];
        spurOvf   = Rx_Overflow & ~ovfPrev & (state == OPEN) & ~ovfSeen;
        errNow[0] = ChkEn[0] & flagDue & ~Rx_FlagDetect;
        errNow[1] = ChkEn[1] & abortDue & ~Rx_AbortSignal;
        errNow[2] = ChkEn[2] & ((ovfDue & ~Rx_Overflow) | spurOvf);
        errCount  = 2'(errNow[0]) + 2'(errNow[1]) + 2'(errNow[2]);
    end

    // Rx history and expectation pipelines
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rxHist    <= '0;
            flagPipe  <= '0;
            abortPipe <= '0;
            ovfPipe   <= '0;
            ovfPrev   <= 1'b0;
        end else begin
            rxHist    <= {rxHist[5:0], Rx};
            flagPipe  <= {flagPipe[MAX_LAT-2:0], flagMatch};
            abortPipe <= {abortPipe[MAX_LAT-2:0], Rx_ValidFrame & Rx_AbortDetect};
            ovfPipe   <= {ovfPipe[MAX_LAT-2:0], ovfPush};
            ovfPrev   <= Rx_Overflow;
        end
    end

    // Frame-tracking state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Frame-tracking next state: any flag opens/keeps a frame, idle or abort closes it
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (flagMatch) stateNext = OPEN;
            OPEN:    if (idleMatch) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign FrameActive = (state == OPEN);

    // Per-frame byte count and overflow-seen tracking; a flag clear beats a write
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ByteCnt <= '0;
            ovfSeen <= 1'b0;
        end else if (flagMatch) begin
            ByteCnt <= '0;
            if (state == OPEN) begin
                ovfSeen <= 1'b0;
            end
        end else begin
            if ((state == OPEN) && Rx_WrBuff && (ByteCnt != BYTES_OVER)) begin
                ByteCnt <= ByteCnt + BC_W'(1);
            end
            if (ovfPush) begin
                ovfSeen <= 1'b1;
            end
        end
    end

    // Registered error pulses
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ErrPulse <= '0;
        end else begin
            ErrPulse <= errNow;
        end
    end

    // Saturating error counters; clear overrides increment
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ErrCntFlag  <= '0;
            ErrCntAbort <= '0;
            ErrCntOvf   <= '0;
            ErrCntTotal <= '0;
        end else if (CntClr) begin
            ErrCntFlag  <= '0;
            ErrCntAbort <= '0;
            ErrCntOvf   <= '0;
            ErrCntTotal <= '0;
        end else begin
            ErrCntFlag  <= satAdd(ErrCntFlag, {1'b0, errNow[0]});
            ErrCntAbort <= satAdd(ErrCntAbort, {1'b0, errNow[1]});
            ErrCntOvf   <= satAdd(ErrCntOvf, {1'b0, errNow[2]});
            ErrCntTotal <= satAdd(ErrCntTotal, errCount);
        end
    end

`ifdef HDLC_MON_PASS_CNT_EN
    logic [2:0] passNow;

    // Successful evaluation of an enabled expectation
    always_comb begin
        passNow[0] = ChkEn[0] & flagDue & Rx_FlagDetect;
        passNow[1] = ChkEn[1] & abortDue & Rx_AbortSignal;
        passNow[2] = ChkEn[2] & ovfDue & Rx_Overflow;
    end

    // Saturating pass counters; clear overrides increment
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            PassCntFlag  <= '0;
            PassCntAbort <= '0;
            PassCntOvf   <= '0;
        end else if (CntClr) begin
            PassCntFlag  <= '0;
            PassCntAbort <= '0;
            PassCntOvf   <= '0;
        end else begin
            PassCntFlag  <= satAdd(PassCntFlag, {1'b0, passNow[0]});
            PassCntAbort <= satAdd(PassCntAbort, {1'b0, passNow[1]});
            PassCntOvf   <= satAdd(PassCntOvf, {1'b0, passNow[2]});
        end
    end
`endif

endmodule
